// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl
// Drives one shared pipelined adder/subtractor through two passes to get a
// fully reduced (A + B) mod M or (A - B) mod M.
//
// Ports
//   clk, resetn          : clock (rising edge), asynchronous active-low reset
//   start, subtract      : request strobe (taken only in IDLE), 0 = add, 1 = sub
//   in_a, in_b, modulus  : operands, latched on acceptance (A, B < M < 2^1026)
//   busy, done, result   : status, one-cycle completion pulse, reduced result
//   add_a, add_b,        : operands and mode driven to the shared adder
//   add_subtract
//   add_result           : adder output, bit 1027 = carry / borrow
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// OP1   | raw pass: A op B, wait ADD_LAT cycles, capture R1
// OP2   | correction pass: R1 (~op) M, wait ADD_LAT cycles, pick result
// DONE  | done pulse, result valid, back to IDLE

module mod_addsub_ctrl #(
    parameter int ADD_LAT    = 1,
    parameter bit CONST_TIME = 1'b0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          subtract,
    input  logic [1026:0] in_a,
    input  logic [1026:0] in_b,
    input  logic [1026:0] modulus,
    output logic          busy,
    output logic          done,
    output logic [1026:0] result,
    output logic [1026:0] add_a,
    output logic [1026:0] add_b,
    output logic          add_subtract,
    input  logic [1027:0] add_result
);

    localparam int CNT_W = $clog2(ADD_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP1,
        S_OP2,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [1026:0]      m_q, m_d;
    logic [1027:0]      r1_q, r1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1026:0]      result_q, result_d;
    logic [1026:0]      add_a_q, add_a_d;
    logic [1026:0]      add_b_q, add_b_d;
    logic               add_sub_q, add_sub_d;
    logic               at_lat;

    assign at_lat = (cnt_q == CNT_W'(ADD_LAT));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        m_d       = m_q;
        r1_d      = r1_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_sub_d = add_sub_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_OP1;
                    cnt_d     = '0;
                    op_d      = subtract;
                    m_d       = modulus;
                    // The adder operand registers double as A_r / B_r.
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    add_sub_d = subtract;
                    busy_d    = 1'b1;
                end
            end

            S_OP1: begin
                cnt_d = cnt_q + 1'b1;
                if (at_lat) begin
                    cnt_d = '0;
                    r1_d  = add_result;
                    // Add always needs the trial subtraction of M; subtract
                    // needs +M only on borrow unless the pass is forced.
                    if (!op_q || add_result[1027] || CONST_TIME) begin
                        state_d   = S_OP2;
                        add_a_d   = add_result[1026:0];
                        add_b_d   = m_q;
                        add_sub_d = ~op_q;
                    end else begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = add_result[1026:0];
                    end
                end
            end

            S_OP2: begin
                cnt_d = cnt_q + 1'b1;
                if (at_lat) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (!op_q) begin
                        // Borrow on R1 - M means R1 was already below M.
                        result_d = add_result[1027] ? r1_q[1026:0] : add_result[1026:0];
                    end else begin
                        // Carry out of R1 + M is the wrap back into range; drop it.
                        result_d = r1_q[1027] ? add_result[1026:0] : r1_q[1026:0];
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            m_q       <= '0;
            r1_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_sub_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            m_q       <= m_d;
            r1_q      <= r1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_sub_q <= add_sub_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign add_subtract = add_sub_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Scoreboard bench for mod_addsub_ctrl. Three instances share the request
// inputs: (ADD_LAT=1, CONST_TIME=0), (ADD_LAT=2, CONST_TIME=0) and
// (ADD_LAT=1, CONST_TIME=1). Each has its own behavioural adder pipeline and
// its own expectation queue drained by a monitor on done.

module tb_mod_addsub_ctrl;

    localparam int W = 1027;

    typedef struct {
        logic [W-1:0] res;
        int           st;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] modulus = '0;

    logic         busy0, busy1, busy2;
    logic         done0, done1, done2;
    logic [W-1:0] res0, res1, res2;
    logic [W-1:0] aa0, aa1, aa2;
    logic [W-1:0] ab0, ab1, ab2;
    logic         as0, as1, as2;
    logic [W:0]   ar0 = '0;
    logic [W:0]   ar1 = '0;
    logic [W:0]   p1  = '0;
    logic [W:0]   ar2 = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;
    bit   h0, h1, h2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_addsub_ctrl #(.ADD_LAT(1), .CONST_TIME(1'b0)) u0 (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .modulus(modulus),
        .busy(busy0), .done(done0), .result(res0),
        .add_a(aa0), .add_b(ab0), .add_subtract(as0), .add_result(ar0));

    mod_addsub_ctrl #(.ADD_LAT(2), .CONST_TIME(1'b0)) u1 (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .modulus(modulus),
        .busy(busy1), .done(done1), .result(res1),
        .add_a(aa1), .add_b(ab1), .add_subtract(as1), .add_result(ar1));

    mod_addsub_ctrl #(.ADD_LAT(1), .CONST_TIME(1'b1)) u2 (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .modulus(modulus),
        .busy(busy2), .done(done2), .result(res2),
        .add_a(aa2), .add_b(ab2), .add_subtract(as2), .add_result(ar2));

    // Environment adder: plain 1028-bit add/sub, delayed ADD_LAT clocks.
    function automatic logic [W:0] addf(logic [W-1:0] a, logic [W-1:0] b, logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    always @(posedge clk) begin
        ar0 <= addf(aa0, ab0, as0);
        p1  <= addf(aa1, ab1, as1);
        ar1 <= p1;
        ar2 <= addf(aa2, ab2, as2);
    end

    // Reference: modular arithmetic from first principles.
    function automatic logic [W-1:0] ref_model(logic [W-1:0] a, logic [W-1:0] b,
                                               logic [W-1:0] m, logic sub);
        logic [W:0] t;
        if (!sub) begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end else if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return t[W-1:0];
    endfunction

    function automatic int lat(int l, bit ct, logic sub, logic [W-1:0] a, logic [W-1:0] b);
        if (sub && !ct && a >= b) return l + 2;
        return 2 * (l + 1) + 1;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v = '0;
        for (int i = 0; i < 33; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    task automatic cmp(string n, logic [W-1:0] act, logic [W-1:0] exp);
        logic [127:0] al, el;
        checks++;
        if (act !== exp) begin
            errors++;
            al = act[127:0];
            el = exp[127:0];
            $display("FAIL %s: got[127:0]=%h want[127:0]=%h (cycle %0d)", n, al, el, cyc);
        end
    endtask

    task automatic cmp_i(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic step(string n, logic b, logic d, logic [W-1:0] r, bit have, exp_t e);
        cmp({n, " busy"}, W'(b), W'(have && cyc > e.st));
        if (d) begin
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL %s spurious done: got done=1 want no done (cycle %0d)", n, cyc);
            end else begin
                cmp({n, " result"}, r, e.res);
                cmp_i({n, " done cycle"}, cyc - e.st, e.due - e.st);
            end
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            h0 = q0.size() > 0;
            if (h0) e0 = q0[0];
            step("d0", busy0, done0, res0, h0, e0);
            if (done0 && h0) void'(q0.pop_front());
            h1 = q1.size() > 0;
            if (h1) e1 = q1[0];
            step("d1", busy1, done1, res1, h1, e1);
            if (done1 && h1) void'(q1.pop_front());
            h2 = q2.size() > 0;
            if (h2) e2 = q2[0];
            step("d2", busy2, done2, res2, h2, e2);
            if (done2 && h2) void'(q2.pop_front());
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy0 || busy1 || busy2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle timeout: got busy=%b%b%b want 000", busy0, busy1, busy2);
        end
    endtask

    // Leaves the caller at the negedge of cycle 1 with start low and the
    // request inputs scrambled.
    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] m, logic sub);
        exp_t e;
        wait_idle();
        start    = 1'b1;
        subtract = sub;
        in_a     = a;
        in_b     = b;
        modulus  = m;
        e.res = ref_model(a, b, m, sub);
        e.st  = cyc;
        e.due = cyc + lat(1, 1'b0, sub, a, b);
        q0.push_back(e);
        e.due = cyc + lat(2, 1'b0, sub, a, b);
        q1.push_back(e);
        e.due = cyc + lat(1, 1'b1, sub, a, b);
        q2.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        subtract = ~sub;
        in_a     = rand_w();
        in_b     = rand_w();
        modulus  = rand_w();
    endtask

    // From the negedge of cycle 1, pulse start with junk at cycle n.
    task automatic pulse_at(int n);
        repeat (n - 1) @(negedge clk);
        start    = 1'b1;
        subtract = 1'b0;
        in_a     = W'(1);
        in_b     = W'(2);
        modulus  = W'(7);
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [W-1:0] big, ra, rb, rm;

    initial begin
        #1 resetn = 1'b0;
        #1;
        cmp("reset busy", W'(busy0), W'(0));
        cmp("reset done", W'(done0), W'(0));
        cmp("reset result", res0, '0);
        cmp("reset add_a", aa0, '0);
        cmp("reset add_b", ab0, '0);
        cmp("reset add_subtract", W'(as0), W'(0));
        cmp("reset busy d1 d2", W'({busy1, busy2}), W'(0));
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;

        issue(W'(5), W'(6), W'(13), 1'b0);
        issue(W'(9), W'(7), W'(13), 1'b0);
        big = '0;
        big[1026] = 1'b1;
        big = big - 1'b1;
        issue(big - 1'b1, big - 1'b1, big, 1'b0);
        issue(W'(9), W'(4), W'(13), 1'b1);
        issue(W'(4), W'(9), W'(13), 1'b1);
        issue(W'(0), W'(12), W'(13), 1'b1);

        // Re-pulse during OP1 (all three in OP1 at cycle 2).
        issue(W'(8), W'(3), W'(13), 1'b0);
        pulse_at(2);
        // Pulse in d0's DONE cycle (cycle 5); d1, d2 still busy.
        issue(W'(10), W'(11), W'(13), 1'b0);
        pulse_at(5);

        // Reset abort while d0 is in OP2.
        issue(W'(7), W'(8), W'(13), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        cmp("abort busy", W'({busy0, busy1, busy2}), W'(0));
        cmp("abort done", W'({done0, done1, done2}), W'(0));
        cmp("abort result d0", res0, '0);
        cmp("abort result d1", res1, '0);
        q0.delete();
        q1.delete();
        q2.delete();
        @(posedge clk);
        #3 resetn = 1'b1;
        issue(W'(0), W'(0), W'(13), 1'b0);

        for (int i = 0; i < 40; i++) begin
            rm = rand_w() >> $urandom_range(0, 1024);
            rm[1026] = 1'b0;
            if (rm == '0) rm = W'(1);
            ra = rand_w() % rm;
            rb = rand_w() % rm;
            if (i % 8 == 3) rb = ra;
            issue(ra, rb, rm, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        cmp_i("pending d0", q0.size(), 0);
        cmp_i("pending d1", q1.size(), 0);
        cmp_i("pending d2", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
